// File: rtl/l2_arbiter_pkg.sv
// Shared LC-3b memory-hierarchy types used by the L2 arbiter.
//   lc3b_word      : 16-bit byte address
//   lc3b_line      : 128-bit cache line
//   lc3b_arb_state : arbiter FSM state, encoded with the ST_* constants
package l2_arbiter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SERVE_I = 2'd1;
  localparam logic [1:0] ST_SERVE_D = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    SERVE_I = ST_SERVE_I,
    SERVE_D = ST_SERVE_D,
    RECOVER = ST_RECOVER
  } lc3b_arb_state;

  // Clear the byte offset so the L2 always sees a line-aligned address.
  function automatic lc3b_word line_align(input lc3b_word addr);
    return {addr[15:4], 4'h0};
  endfunction

endpackage

// File: rtl/l2_arbiter.sv
// Two-port arbiter sharing the single L2 port between the L1 I-cache and the
// L1 D-cache. One 128-bit line transaction is in flight at a time.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   icache_read/address          I-cache fill request (held until icache_resp)
//   icache_rdata/resp            fill line and one-cycle completion pulse
//   dcache_read/write/address    D-cache fill or writeback request
//   dcache_wdata                 writeback line
//   dcache_rdata/resp            fill line and one-cycle completion pulse
//   l2_read/write/address/wdata  request to the L2 (registered/state-decoded)
//   l2_rdata/resp                L2 read line and completion pulse
//   state_dbg                    current FSM state, for observation
//
// Handshake: an L1 raises read/write and holds it, with its address/data,
// until its resp pulse. The arbiter samples requests only in IDLE; the winner's
// request is latched and held on the L2 port until l2_resp. RECOVER swallows
// the cycle after resp in which the L1 may still hold its request high.
module l2_arbiter
  import l2_arbiter_pkg::*;
#(
  parameter int unsigned DCACHE_FIRST = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          icache_read,
  input  lc3b_word      icache_address,
  output lc3b_line      icache_rdata,
  output logic          icache_resp,
  input  logic          dcache_read,
  input  logic          dcache_write,
  input  lc3b_word      dcache_address,
  input  lc3b_line      dcache_wdata,
  output lc3b_line      dcache_rdata,
  output logic          dcache_resp,
  output logic          l2_read,
  output logic          l2_write,
  output lc3b_word      l2_address,
  output lc3b_line      l2_wdata,
  input  lc3b_line      l2_rdata,
  input  logic          l2_resp,
  output lc3b_arb_state state_dbg
);

  lc3b_arb_state state;
  logic          last_d;    // 1 when the most recent grant went to the D-cache
  logic          op_write;  // latched operation of the current transaction
  lc3b_word      addr_q;
  lc3b_line      wdata_q;

  logic i_req;
  logic d_req;
  logic d_wins;
  logic serving;

  assign i_req = icache_read;
  assign d_req = dcache_read | dcache_write;

  // On a tie, round-robin favours whoever did not win last time.
  always_comb begin
    d_wins = 1'b0;
    if (d_req && !i_req) begin
      d_wins = 1'b1;
    end else if (d_req && i_req) begin
      d_wins = (DCACHE_FIRST != 0) ? 1'b1 : !last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last_d   <= 1'b0;
      op_write <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            state    <= d_wins ? SERVE_D : SERVE_I;
            last_d   <= d_wins;
            // Write beats read if the D-cache illegally raises both.
            op_write <= d_wins & dcache_write;
            addr_q   <= line_align(d_wins ? dcache_address : icache_address);
            wdata_q  <= dcache_wdata;
          end
        end
        SERVE_I, SERVE_D: begin
          if (l2_resp) state <= RECOVER;
        end
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // L2 request outputs depend only on state and latch registers.
  assign serving    = (state == SERVE_I) || (state == SERVE_D);
  assign l2_read    = serving & ~op_write;
  assign l2_write   = serving & op_write;
  assign l2_address = addr_q;
  assign l2_wdata   = wdata_q;

  assign icache_resp  = (state == SERVE_I) & l2_resp;
  assign dcache_resp  = (state == SERVE_D) & l2_resp;
  assign icache_rdata = l2_rdata;
  assign dcache_rdata = l2_rdata;

  assign state_dbg = state;

endmodule

// File: tb/tb_l2_arbiter.sv
module tb_l2_arbiter;
  import l2_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          icache_read = 0, dcache_read = 0, dcache_write = 0;
  lc3b_word      icache_address = '0, dcache_address = '0;
  lc3b_line      dcache_wdata = '0, l2_rdata = '0;
  logic          l2_resp = 0, l2_resp_df = 0;

  lc3b_line      icache_rdata, dcache_rdata, l2_wdata;
  logic          icache_resp, dcache_resp, l2_read, l2_write;
  lc3b_word      l2_address;
  lc3b_arb_state state_dbg;

  lc3b_line      icache_rdata_df, dcache_rdata_df, l2_wdata_df;
  logic          icache_resp_df, dcache_resp_df, l2_read_df, l2_write_df;
  lc3b_word      l2_address_df;
  lc3b_arb_state state_df;

  l2_arbiter #(.DCACHE_FIRST(0)) dut (
    .clk(clk), .reset(reset),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .state_dbg(state_dbg)
  );

  l2_arbiter #(.DCACHE_FIRST(1)) dut_df (
    .clk(clk), .reset(reset),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_rdata(icache_rdata_df), .icache_resp(icache_resp_df),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata_df), .dcache_resp(dcache_resp_df),
    .l2_read(l2_read_df), .l2_write(l2_write_df), .l2_address(l2_address_df),
    .l2_wdata(l2_wdata_df), .l2_rdata(l2_rdata), .l2_resp(l2_resp_df),
    .state_dbg(state_df)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];  // expected owner of each upcoming response: 1=I, 2=D

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model (DCACHE_FIRST=0 instance) ----------------
  // Owner of the L2 port (0 none, 1 I, 2 D), a one-cycle cooldown after each
  // response, and the history of grants that drives the tie rule.
  int         grants[$];
  int         m_owner = 0;
  bit         m_cool = 0;
  bit         m_write = 0;
  lc3b_word   m_addr = '0;
  lc3b_line   m_wdata = '0;

  always @(posedge clk) begin : model
    bit ir, dr, pick_d;
    ir = icache_read;
    dr = dcache_read | dcache_write;
    if (reset) begin
      m_owner = 0; m_cool = 0; m_write = 0; m_addr = '0; m_wdata = '0;
      grants.delete();
    end else if (m_owner != 0) begin
      if (l2_resp) begin
        m_owner = 0;
        m_cool = 1;
      end
    end else if (m_cool) begin
      m_cool = 0;
    end else if (ir || dr) begin
      if (ir && dr) pick_d = (grants.size() == 0) ? 1'b1 : (grants[$] == 1);
      else          pick_d = dr;
      grants.push_back(pick_d ? 2 : 1);
      m_owner = pick_d ? 2 : 1;
      m_write = pick_d && dcache_write;
      m_addr  = pick_d ? (dcache_address & 16'hFFF0) : (icache_address & 16'hFFF0);
      m_wdata = dcache_wdata;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("l2_read",      l2_read,      (m_owner != 0) && !m_write);
    check("l2_write",     l2_write,     (m_owner != 0) && m_write);
    check("l2_address",   l2_address,   m_addr);
    check("l2_wdata",     l2_wdata,     m_wdata);
    check("icache_resp",  icache_resp,  (m_owner == 1) && l2_resp);
    check("dcache_resp",  dcache_resp,  (m_owner == 2) && l2_resp);
    check("icache_rdata", icache_rdata, l2_rdata);
    check("dcache_rdata", dcache_rdata, l2_rdata);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    icache_read = 0; dcache_read = 0; dcache_write = 0; l2_resp = 0; l2_resp_df = 0;
  endtask

  task automatic pulse_reset();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic wait_req(input bit use_df, input string name);
    bit ok;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      if (use_df ? (l2_read_df | l2_write_df) : (l2_read | l2_write)) begin
        ok = 1;
        break;
      end
      step();
    end
    check(name, ok, 1'b1);
  endtask

  function automatic lc3b_line rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    lc3b_line pat;
    logic [1:0] who;

    // Reset state
    repeat (2) step();
    #2;
    check("rst_state", state_dbg, IDLE);
    check("rst_l2_read", l2_read, 1'b0);
    check("rst_l2_write", l2_write, 1'b0);
    check("rst_addr", l2_address, 16'h0000);
    check("rst_wdata", l2_wdata, 128'h0);
    check("rst_resp", {icache_resp, dcache_resp}, 2'b00);
    reset = 0;
    step();

    // I read at 0x1236
    icache_read = 1; icache_address = 16'h1236;
    step(); #2;
    check("i_grant_read", l2_read, 1'b1);
    check("i_grant_addr", l2_address, 16'h1230);
    l2_resp = 1; l2_rdata = {16{8'hA5}};
    #1;
    check("i_resp", icache_resp, 1'b1);
    check("i_rdata", icache_rdata, {16{8'hA5}});
    check("i_no_dresp", dcache_resp, 1'b0);
    step();
    l2_resp = 0; icache_read = 0;
    repeat (2) step();

    // D write at 0x4008, inputs change after grant
    pat = {8{16'h1234}};
    dcache_write = 1; dcache_address = 16'h4008; dcache_wdata = pat;
    step(); #2;
    check("d_wr_write", l2_write, 1'b1);
    check("d_wr_read", l2_read, 1'b0);
    check("d_wr_addr", l2_address, 16'h4000);
    dcache_write = 0; dcache_read = 1; dcache_address = 16'hFFFF; dcache_wdata = '0;
    icache_read = 1; icache_address = 16'h7777;
    repeat (3) step();
    #2;
    check("d_wr_hold_write", l2_write, 1'b1);
    check("d_wr_hold_addr", l2_address, 16'h4000);
    check("d_wr_hold_wdata", l2_wdata, pat);
    l2_resp = 1;
    #1;
    check("d_wr_resp", dcache_resp, 1'b1);
    check("d_wr_no_iresp", icache_resp, 1'b0);
    step();
    idle_inputs();
    repeat (2) step();

    // Turnaround with request held continuously: next grant no earlier than M+3
    icache_read = 1; icache_address = 16'h0010;
    step();
    l2_resp = 1;          // cycle M
    step();
    l2_resp = 0; #2;      // M+1
    check("ta_m1", l2_read, 1'b0);
    check("ta_m1_state", state_dbg, RECOVER);
    step(); #2;           // M+2
    check("ta_m2", l2_read, 1'b0);
    step(); #2;           // M+3
    check("ta_m3", l2_read, 1'b1);
    // Request held one cycle past resp, then dropped: exactly one transaction
    l2_resp = 1;
    step();
    l2_resp = 0;          // M+1, request still high
    step();
    icache_read = 0;      // M+2
    step(); #2;           // M+3
    check("hold1_no_regrant", l2_read, 1'b0);
    check("hold1_state", state_dbg, IDLE);
    step();

    // Reset in the middle of SERVE_D
    dcache_read = 1; dcache_address = 16'h5554; dcache_wdata = rand_line();
    step(); #2;
    check("mid_serve_d", l2_read, 1'b1);
    reset = 1; dcache_read = 0;
    step();
    reset = 0; #2;
    check("mid_rst_state", state_dbg, IDLE);
    check("mid_rst_outs", {l2_read, l2_write, icache_resp, dcache_resp}, 4'b0000);
    check("mid_rst_addr", l2_address, 16'h0000);
    check("mid_rst_wdata", l2_wdata, 128'h0);
    icache_read = 1; icache_address = 16'h2222;
    step(); #2;
    check("post_rst_read", l2_read, 1'b1);
    check("post_rst_addr", l2_address, 16'h2220);
    l2_resp = 1;
    #1;
    check("post_rst_resp", icache_resp, 1'b1);
    step();
    idle_inputs();
    repeat (2) step();

    // Round-robin ties from reset: D, I, D, I, D, I
    pulse_reset();
    exp_q = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
    icache_read = 1; dcache_read = 1;
    icache_address = 16'h1111; dcache_address = 16'h2222;
    for (int k = 0; k < 6; k++) begin
      wait_req(0, "rr_wait");
      l2_resp = 1;
      #2;
      who = exp_q.pop_front();
      check("rr_owner", {icache_resp, dcache_resp}, (who == 2'd1) ? 2'b10 : 2'b01);
      step();
      l2_resp = 0;
    end
    check("rr_model_count", grants.size(), 6);
    if (grants.size() == 6) begin
      check("rr_model_0", grants[0], 2);
      check("rr_model_1", grants[1], 1);
    end
    idle_inputs();
    repeat (2) step();

    // DCACHE_FIRST=1: D wins every tie
    pulse_reset();
    icache_read = 1; dcache_read = 1;
    for (int k = 0; k < 4; k++) begin
      wait_req(1, "df_wait");
      l2_resp_df = 1;
      #2;
      check("df_owner", {icache_resp_df, dcache_resp_df}, 2'b01);
      step();
      l2_resp_df = 0;
    end
    idle_inputs();
    pulse_reset();
    step();

    // Randomized traffic checked by the model each cycle
    for (int n = 0; n < 3000; n++) begin
      reset          = ($urandom_range(0, 299) == 0);
      icache_read    = $urandom_range(0, 1);
      dcache_read    = ($urandom_range(0, 2) == 0);
      dcache_write   = ($urandom_range(0, 3) == 0);
      icache_address = $urandom_range(0, 16'hFFFF);
      dcache_address = $urandom_range(0, 16'hFFFF);
      dcache_wdata   = rand_line();
      l2_rdata       = rand_line();
      l2_resp        = (m_owner != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      step();
    end
    reset = 0;
    idle_inputs();
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
